// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register for an inter-stage boundary. It carries a
// control vector, a data vector and a PC under a valid/ready handshake.
// SKID=1 adds a second entry so that in_ready comes from a register.
// flush squashes held entries and counts them in a saturating counter.
module pipe_stage_reg #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 160,
  parameter int                PC_W     = 32,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [15:0]       squash_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_p0, state_nxt;

  // Main entry (_p0) drives the outputs; skid entry (_p1) is always younger.
  logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p1;
  logic [DATA_W-1:0] main_data_p0, skid_data_p1;
  logic [PC_W-1:0]   main_pc_p0,   skid_pc_p1;
  logic              vld_p0, vld_p1;
  logic [15:0]       squash_cnt_q;

  logic transfer, consume;
  logic ld_main_in, ld_main_skid, ld_skid;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign vld_p0    = (state_p0 != EMPTY);
  assign vld_p1    = (state_p0 == TWO);
  assign occupancy = {vld_p1, vld_p0 & ~vld_p1};

  // Ready: registered-only in skid mode, combinational pass-through otherwise.
  always_comb begin
    if (SKID != 0) in_ready = ~vld_p1 & ~flush;
    else           in_ready = (~vld_p0 | out_ready) & ~flush;
  end

  // A flush cycle never counts as a consume, even if downstream had out_ready high.
  assign transfer = in_valid & in_ready;
  assign consume  = vld_p0 & out_ready & ~flush;

  // Next-state and entry-load decode.
  always_comb begin
    state_nxt    = state_p0;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (transfer) begin
            ld_main_in = 1'b1;
            state_nxt  = ONE;
          end
        end
        ONE: begin
          if (transfer && consume) begin
            ld_main_in = 1'b1;
          end else if (transfer) begin
            ld_skid   = 1'b1;
            state_nxt = TWO;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            ld_main_skid = 1'b1;
            state_nxt    = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // State register; occupancy is derived from it.
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= EMPTY;
    else     state_p0 <= state_nxt;
  end

  // Entry storage; main refills from skid to preserve arrival order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      main_pc_p0   <= '0;
      skid_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
      skid_pc_p1   <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl_p0 <= in_ctrl;
        main_data_p0 <= in_data;
        main_pc_p0   <= in_pc;
      end else if (ld_main_skid) begin
        main_ctrl_p0 <= skid_ctrl_p1;
        main_data_p0 <= skid_data_p1;
        main_pc_p0   <= skid_pc_p1;
      end
      if (ld_skid) begin
        skid_ctrl_p1 <= in_ctrl;
        skid_data_p1 <= in_data;
        skid_pc_p1   <= in_pc;
      end
    end
  end

  // Squash counter: adds the entries held in the flush cycle, saturating.
  always_ff @(posedge clk) begin
    if (rst)        squash_cnt_q <= 16'h0000;
    else if (flush) squash_cnt_q <= sat_add(squash_cnt_q, occupancy);
  end

  assign squash_cnt = squash_cnt_q;
  assign out_valid  = vld_p0;
  assign out_ctrl   = vld_p0 ? main_ctrl_p0 : CTRL_RST;
  assign out_data   = vld_p0 ? main_data_p0 : '0;
  assign out_pc     = vld_p0 ? main_pc_p0   : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 is the skid build, instance 1 the
// single-entry build. Each is compared every cycle against a small FIFO model.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 160;
  localparam int PW = 32;
  localparam logic [CW-1:0] RST0 = 16'h0013;
  localparam logic [CW-1:0] RST1 = 16'h00A5;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic fl[2], iv[2], ordy[2];
  beat_t ib[2];
  logic ir[2], ov[2];
  logic [CW-1:0] oc[2];
  logic [DW-1:0] od[2];
  logic [PW-1:0] op[2];
  logic [1:0]    occ[2];
  logic [15:0]   sq[2];

  // Reference model: a bounded FIFO per instance plus a squash tally.
  beat_t mb[2][2];
  int    msz[2];
  int    mcnt[2];
  logic  mrdy[2];
  logic  acc[2];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .CTRL_RST(RST0), .SKID(1)) dut0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_ctrl(ib[0].c), .in_data(ib[0].d), .in_pc(ib[0].p),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(oc[0]), .out_data(od[0]),
    .out_pc(op[0]), .occupancy(occ[0]), .squash_cnt(sq[0]));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .CTRL_RST(RST1), .SKID(0)) dut1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_ctrl(ib[1].c), .in_data(ib[1].d), .in_pc(ib[1].p),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(oc[1]), .out_data(od[1]),
    .out_pc(op[1]), .occupancy(occ[1]), .squash_cnt(sq[1]));

  function automatic beat_t mk(input logic [PW-1:0] pc);
    beat_t b;
    b.c = CW'($urandom);
    b.d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b.p = pc;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances with the model, then clock once and advance the model.
  task automatic tick();
    logic [CW-1:0] rc;
    beat_t h;
    #1;
    for (int k = 0; k < 2; k++) begin
      rc = (k == 0) ? RST0 : RST1;
      h  = mb[k][0];
      if (k == 0) mrdy[k] = !fl[k] && (msz[k] < 2);
      else        mrdy[k] = !fl[k] && (msz[k] == 0 || ordy[k]);
      chk($sformatf("in_ready[%0d]", k),   256'(ir[k]),  256'(mrdy[k]));
      chk($sformatf("out_valid[%0d]", k),  256'(ov[k]),  256'(msz[k] > 0));
      chk($sformatf("out_ctrl[%0d]", k),   256'(oc[k]),  256'((msz[k] > 0) ? h.c : rc));
      chk($sformatf("out_data[%0d]", k),   256'(od[k]),  256'((msz[k] > 0) ? h.d : '0));
      chk($sformatf("out_pc[%0d]", k),     256'(op[k]),  256'((msz[k] > 0) ? h.p : '0));
      chk($sformatf("occupancy[%0d]", k),  256'(occ[k]), 256'(msz[k]));
      chk($sformatf("squash_cnt[%0d]", k), 256'(sq[k]),  256'(mcnt[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      acc[k] = !rst && iv[k] && mrdy[k];
      if (rst) begin
        msz[k] = 0;
        mcnt[k] = 0;
      end else if (fl[k]) begin
        mcnt[k] = (mcnt[k] + msz[k] > 65535) ? 65535 : mcnt[k] + msz[k];
        msz[k] = 0;
      end else begin
        if (msz[k] > 0 && ordy[k]) begin
          mb[k][0] = mb[k][1];
          msz[k]--;
        end
        if (acc[k]) begin
          mb[k][msz[k]] = ib[k];
          msz[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic wait_acc(input int k);
    int n;
    n = 0;
    tick();
    while (!acc[k] && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("accept[%0d]", k), 256'(acc[k]), 256'(1));
  endtask

  task automatic send(input int k, input logic [PW-1:0] pc);
    ib[k] = mk(pc);
    iv[k] = 1'b1;
    wait_acc(k);
  endtask

  task automatic fill2_flush0();
    ordy[0] = 1'b0;
    send(0, 32'h500);
    send(0, 32'h504);
    iv[0] = 1'b0;
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      fl[k] = 1'b0; iv[k] = 1'b1; ordy[k] = 1'b0; ib[k] = mk(32'h0);
      msz[k] = 0; mcnt[k] = 0; acc[k] = 1'b0; mrdy[k] = 1'b0;
    end
    // Reset with upstream valid held high.
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("rst_out_valid", 256'(ov[0]), 256'(0));
    chk("rst_out_ctrl",  256'(oc[0]), 256'(RST0));
    chk("rst_occupancy", 256'(occ[0]), 256'(0));
    chk("rst_squash",    256'(sq[0]), 256'(0));
    chk("rst_in_ready",  256'(ir[0]), 256'(1));
    tick();

    // Streaming at full rate.
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) send(0, 32'h100 + 32'(4 * i));
    iv[0] = 1'b0;
    tick();
    tick();

    // Backpressure fills both entries, then drains in order.
    ordy[0] = 1'b0;
    send(0, 32'h200);
    send(0, 32'h204);
    ib[0] = mk(32'h208);
    iv[0] = 1'b1;
    tick();
    chk("bp_occupancy", 256'(occ[0]), 256'(2));
    chk("bp_in_ready",  256'(ir[0]), 256'(0));
    chk("bp_head_pc",   256'(op[0]), 256'(32'h200));
    tick();
    ordy[0] = 1'b1;
    wait_acc(0);
    iv[0] = 1'b0;
    tick();
    tick();
    tick();

    // Flush with two held and a beat offered.
    ordy[0] = 1'b0;
    send(0, 32'h300);
    send(0, 32'h304);
    ib[0] = mk(32'h308);
    iv[0] = 1'b1;
    fl[0] = 1'b1;
    tick();
    chk("flush_no_accept", 256'(acc[0]), 256'(0));
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    #1;
    chk("flush_out_valid", 256'(ov[0]), 256'(0));
    chk("flush_out_ctrl",  256'(oc[0]), 256'(RST0));
    chk("flush_occupancy", 256'(occ[0]), 256'(0));
    chk("flush_squash",    256'(sq[0]), 256'(2));
    tick();

    // Saturation: a few real flushes, then jump the counter near the top.
    for (int i = 0; i < 3; i++) fill2_flush0();
    chk("squash_accum", 256'(sq[0]), 256'(8));
    force dut0.squash_cnt_q = 16'hFFFE;
    #1;
    release dut0.squash_cnt_q;
    mcnt[0] = 65534;
    fill2_flush0();
    #1;
    chk("squash_sat", 256'(sq[0]), 256'(16'hFFFF));
    fill2_flush0();
    #1;
    chk("squash_hold", 256'(sq[0]), 256'(16'hFFFF));
    tick();

    // Single-entry build: ready follows out_ready combinationally.
    ordy[1] = 1'b0;
    send(1, 32'h400);
    ib[1] = mk(32'h404);
    iv[1] = 1'b1;
    #1;
    chk("noskid_rdy_low", 256'(ir[1]), 256'(0));
    ordy[1] = 1'b1;
    #1;
    chk("noskid_rdy_comb", 256'(ir[1]), 256'(1));
    tick();
    iv[1] = 1'b0;
    ordy[1] = 1'b0;
    #1;
    chk("noskid_replace", 256'(op[1]), 256'(32'h404));
    tick();
    tick();

    // Randomised traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!iv[k] || acc[k]) begin
          iv[k] = ($urandom_range(0, 3) != 0);
          ib[k] = mk($urandom);
        end
        fl[k]   = ($urandom_range(0, 15) == 0);
        ordy[k] = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control vector, a data vector and an instruction PC under a valid/ready handshake. A two-entry skid buffer breaks the ready path, and a flush input squashes in-flight entries into bubbles. It replaces hand-written per-stage registers and the global stall-code decode with local backpressure.

## Interface
Parameters:
- CTRL_W, 16: width of control-bit vector (alu_op, mem_read, reg_write, …).
- DATA_W, 160: width of data vector (rs1/rs2 data, imm, reg addresses).
- PC_W, 32: width of instruction PC.
- CTRL_RST, '0: control value presented whenever no valid entry is on the output (NOP encoding).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries and drop this cycle's input beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data.
- in_pc  in  PC_W  upstream instruction PC.
- out_valid  out  1  output entry valid (has_inst).
- out_ready  in  1  downstream consumes the output entry.
- out_ctrl  out  CTRL_W  output control; CTRL_RST when out_valid=0.
- out_data  out  DATA_W  output data; 0 when out_valid=0.
- out_pc  out  PC_W  output PC; 0 when out_valid=0.
- occupancy  out  2  number of valid entries held (0..2).
- squash_cnt  out  16  saturating count of valid entries discarded by flush.

## Operation
- Storage: main entry (drives outputs) and skid entry (SKID=1 only), each with a valid bit.
- A transfer occurs when in_valid & in_ready. A consume occurs when out_valid & out_ready.
- SKID=1: in_ready = !skid_v & !flush, with skid_v from a register. State machine EMPTY/ONE/TWO, equal to occupancy:
  - EMPTY: transfer → main ← input, go to ONE.
  - ONE: transfer & consume → main ← input, stay in ONE. Transfer only → skid ← input, go to TWO. Consume only → go to EMPTY. Neither → hold.
  - TWO: in_ready=0. Consume → main ← skid, go to ONE. Otherwise hold.
- SKID=0: in_ready = (!main_v | out_ready) & !flush. Main loads on transfer and clears on consume without transfer. Occupancy is 0 or 1.
- Output masking: when out_valid=0, out_ctrl=CTRL_RST and out_data=out_pc=0, regardless of stale storage.
- Ordering: entries leave in arrival order; main is always older than skid.
- flush (priority below rst, above all else):
  - Next cycle: both valids=0, state EMPTY.
  - The input beat in the flush cycle is not accepted.
  - The output entry is not considered consumed by downstream.
  - squash_cnt += occupancy in the flush cycle, saturating at 16'hFFFF.
- rst overrides flush and the handshake:
  - All valids 0, state EMPTY, squash_cnt 0, storage cleared.
  - Any entries held at reset are lost and are not counted.

## Timing
- Reset values: out_valid 0, out_ctrl CTRL_RST, out_data 0, out_pc 0, occupancy 0, squash_cnt 0, in_ready 1 (when flush=0).
- Latency: a beat accepted at edge N is on the outputs after edge N (visible in cycle N+1). There is no combinational in→out path.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- SKID=1: in_ready depends only on registers and flush, so there is no out_ready→in_ready path. in_ready falls the cycle after the second entry is captured.
- SKID=0: out_ready→in_ready is combinational; integration must budget for this path.
- Upstream must hold in_valid and its payload stable until accepted. Downstream may drop out_ready at any time.
- Simultaneous flush + consume: the flush wins and squash_cnt counts the consumed entry too. Downstream must qualify its consume with !flush.
- squash_cnt at 16'hFFFF stays there. At 16'hFFFE, a flush with occupancy=2 yields 16'hFFFF.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, out_ctrl=CTRL_RST, occupancy=0, squash_cnt=0, in_ready=1 after release.
- Streaming: 8 beats pc=0x100..0x11C, out_ready=1 → outputs appear one cycle after each accept, in order, no gaps, occupancy stays 1.
- Backpressure (SKID=1): out_ready=0 while sending pc=0x200, 0x204, 0x208 → first two captured, in_ready=0 from the third cycle, occupancy=2. Raise out_ready → 0x200, 0x204, 0x208 delivered in order with no loss or duplicates.
- Flush with 2 entries held and in_valid=1 → next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0, squash_cnt=2, and the input beat is not accepted.
- Saturation: preload squash_cnt to 0xFFFE via repeated flushes, then flush with occupancy=2 → squash_cnt=0xFFFF. A further flush leaves it at 0xFFFF.
- SKID=0 build: out_ready=0 with main valid → in_ready=0 in the same cycle. Toggle out_ready=1 → in_ready=1 combinationally and the new beat replaces main.
